// File: rtl/prefix_pipe_if.sv
// Operand and result handshake bundle for the pipelined Kogge-Stone prefix adder.
// The slave view belongs to the pipeline; the master view belongs to its upstream/downstream.
interface prefix_pipe_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] p_in;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  g_in,
    input  a_in,
    input  p_in,
    input  cin,
    input  in_valid,
    output in_ready,
    output sum,
    output cout,
    output out_valid,
    input  out_ready
  );

  modport master (
    output g_in,
    output a_in,
    output p_in,
    output cin,
    output in_valid,
    input  in_ready,
    input  sum,
    input  cout,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/prefix_pipe.sv
// Pipelined Kogge-Stone carry network plus sum register: S0 input stage, one stage per
// prefix level, then the sum stage. Per-stage valid/ready lets bubbles collapse under stall.
module prefix_pipe #(
  parameter int WIDTH = 16,
  parameter int LOG2W = 4
) (
  input  logic         clk,
  input  logic         rst,
  prefix_pipe_if.slave bus
);

  if (WIDTH < 2 || (1 << LOG2W) != WIDTH) begin : g_paramCheck
    $error("prefix_pipe: WIDTH must be a power of two >= 2 and LOG2W must equal clog2(WIDTH)");
  end

  // Stage k = 0..LOG2W; alive bits are only kept where a later level still consumes them
  logic [LOG2W:0]              r_valid;
  logic [LOG2W:0][WIDTH-1:0]   r_g;
  logic [LOG2W-1:0][WIDTH-1:0] r_a;
  logic [LOG2W:0][WIDTH-1:0]   r_p;
  logic [LOG2W:0]              r_cin;
  logic [WIDTH-1:0]            r_sum;
  logic                        r_cout;
  logic                        r_outValid;

  wire                         w_readyOut;
  wire [LOG2W:0]               w_ready;
  wire [LOG2W:0]               w_validD;
  wire [LOG2W:0][WIDTH-1:0]    w_gD;
  wire [LOG2W-1:0][WIDTH-1:0]  w_aD;
  wire [LOG2W:0][WIDTH-1:0]    w_pD;
  wire [LOG2W:0]               w_cinD;
  wire [WIDTH-1:0]             w_g0;
  wire [WIDTH-1:0]             w_carry;

  assign w_readyOut     = bus.out_ready | ~r_outValid;
  assign w_ready[LOG2W] = ~r_valid[LOG2W] | w_readyOut;

  for (genvar k = 0; k < LOG2W; k++) begin : g_readyChain
    assign w_ready[k] = ~r_valid[k] | w_ready[k+1];
  end

  // Folding cin into bit 0's generate lets the prefix tree produce every carry directly
  assign w_g0 = {bus.g_in[WIDTH-1:1], bus.g_in[0] | (bus.a_in[0] & bus.cin)};

  assign w_validD[0] = w_ready[0] ? bus.in_valid : r_valid[0];
  assign w_gD[0]     = w_ready[0] ? w_g0         : r_g[0];
  assign w_aD[0]     = w_ready[0] ? bus.a_in     : r_a[0];
  assign w_pD[0]     = w_ready[0] ? bus.p_in     : r_p[0];
  assign w_cinD[0]   = w_ready[0] ? bus.cin      : r_cin[0];

  for (genvar l = 1; l <= LOG2W; l++) begin : g_level
    localparam int D = 1 << (l - 1);
    wire [WIDTH-1:0] w_gLvl;

    for (genvar i = 0; i < WIDTH; i++) begin : g_gen
      if (i >= D) begin : g_cell
        assign w_gLvl[i] = r_g[l-1][i] | (r_a[l-1][i] & r_g[l-1][i-D]);
      end else begin : g_pass
        assign w_gLvl[i] = r_g[l-1][i];
      end
    end

    // The last level's alive span has no consumer, so it is never formed
    if (l < LOG2W) begin : g_alive
      wire [WIDTH-1:0] w_aLvl;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_cell
          assign w_aLvl[i] = r_a[l-1][i] & r_a[l-1][i-D];
        end else begin : g_pass
          assign w_aLvl[i] = r_a[l-1][i];
        end
      end
      assign w_aD[l] = w_ready[l] ? w_aLvl : r_a[l];
    end

    assign w_validD[l] = w_ready[l] ? r_valid[l-1] : r_valid[l];
    assign w_gD[l]     = w_ready[l] ? w_gLvl       : r_g[l];
    assign w_pD[l]     = w_ready[l] ? r_p[l-1]     : r_p[l];
    assign w_cinD[l]   = w_ready[l] ? r_cin[l-1]   : r_cin[l];
  end

  assign w_carry = {r_g[LOG2W][WIDTH-2:0], r_cin[LOG2W]};

  // Bubbles advance the valid bit only, so sum/cout keep the last delivered result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_g        <= '0;
      r_a        <= '0;
      r_p        <= '0;
      r_cin      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_valid <= w_validD;
      r_g     <= w_gD;
      r_a     <= w_aD;
      r_p     <= w_pD;
      r_cin   <= w_cinD;
      if (w_readyOut) begin
        r_outValid <= r_valid[LOG2W];
        if (r_valid[LOG2W]) begin
          r_sum  <= r_p[LOG2W] ^ w_carry;
          r_cout <= r_g[LOG2W][WIDTH-1];
        end
      end
    end
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_prefix_pipe.sv
// Directed and random bench for prefix_pipe; operands are turned into g/a/p by gap cells
// and every result is checked against x+y+cin in acceptance order.
module tb_prefix_pipe;
  localparam int WIDTH = 16;
  localparam int LOG2W = 4;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;

  prefix_pipe_if #(.WIDTH(WIDTH)) bus ();

  prefix_pipe #(.WIDTH(WIDTH), .LOG2W(LOG2W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change at the falling edge; outputs are looked at 1 time unit later
  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.g_in      = x & y;
    bus.a_in      = x | y;
    bus.p_in      = x ^ y;
    bus.cin       = c;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.g_in      = '0;
    bus.a_in      = '0;
    bus.p_in      = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    nChecks++;
    if (bus.out_valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    nChecks++;
    if (bus.sum !== 16'h0) begin
      nFails++; $display("[TB] FAIL reset_sum: got %h expected 0000", bus.sum);
    end
    nChecks++;
    if (bus.cout !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_cout: got %b expected 0", bus.cout);
    end
    nChecks++;
    if (bus.in_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  // Single ops through an empty pipe: latency and hand-computed results
  task automatic test_directed;
    logic [WIDTH-1:0] xv [4];
    logic [WIDTH-1:0] yv [4];
    logic             cv [4];
    logic [WIDTH-1:0] sExp [4];
    logic             cExp [4];
    xv   = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000};
    yv   = '{16'h4321, 16'h0001, 16'hFFFF, 16'h8000};
    cv   = '{1'b0, 1'b0, 1'b1, 1'b1};
    sExp = '{16'h5555, 16'h0000, 16'h0000, 16'h0001};
    cExp = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int t = 0; t < 4; t++) begin
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      drive(1'b1, xv[t], yv[t], cv[t], 1'b1);
      nChecks++;
      if (bus.in_ready !== 1'b1) begin
        nFails++; $display("[TB] FAIL directed%0d_accept: got in_ready=%b expected 1", t, bus.in_ready);
      end
      for (int n = 1; n <= 20 && !seen; n++) begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        if (bus.out_valid === 1'b1) begin
          seen = 1'b1;
          lat  = n;
        end
      end
      nChecks++;
      if (lat != LOG2W + 2) begin
        nFails++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", t, lat, LOG2W + 2);
      end
      nChecks++;
      if ({bus.cout, bus.sum} !== {cExp[t], sExp[t]}) begin
        nFails++;
        $display("[TB] FAIL directed%0d_result: got cout=%b sum=%h expected cout=%b sum=%h",
                 t, bus.cout, bus.sum, cExp[t], sExp[t]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] xq [10];
    logic [WIDTH-1:0] yq [10];
    logic             cq [10];
    logic [WIDTH:0]   expQ [$];
    logic [WIDTH:0]   expV;
    int               idx;
    int               got;
    for (int i = 0; i < 10; i++) begin
      xq[i] = 16'(16'h0101 * (i + 1));
      yq[i] = 16'(16'h1000 + i);
      cq[i] = 1'(i);
    end
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b1, xq[idx], yq[idx], cq[idx], 1'b0);
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back({1'b0, xq[idx]} + {1'b0, yq[idx]} + {{WIDTH{1'b0}}, cq[idx]});
        idx++;
      end
    end
    nChecks++;
    if (idx != LOG2W + 2) begin
      nFails++; $display("[TB] FAIL b2b_capacity: got %0d accepted expected %0d", idx, LOG2W + 2);
    end
    nChecks++;
    if (bus.in_ready !== 1'b0) begin
      nFails++; $display("[TB] FAIL b2b_full_in_ready: got %b expected 0", bus.in_ready);
    end
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      drive(idx < 10, xq[idx % 10], yq[idx % 10], cq[idx % 10], 1'b1);
      if (cyc == 0) begin
        nChecks++;
        if (bus.in_ready !== 1'b1) begin
          nFails++; $display("[TB] FAIL b2b_release_in_ready: got %b expected 1", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        expV = (expQ.size() > 0) ? expQ.pop_front() : '0;
        nChecks++;
        if ({bus.cout, bus.sum} !== expV) begin
          nFails++;
          $display("[TB] FAIL b2b_result%0d: got %h expected %h", got, {bus.cout, bus.sum}, expV);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back({1'b0, xq[idx]} + {1'b0, yq[idx]} + {{WIDTH{1'b0}}, cq[idx]});
        idx++;
      end
    end
    nChecks++;
    if (got != 10) begin
      nFails++; $display("[TB] FAIL b2b_count: got %0d results expected 10", got);
    end
  endtask

  task automatic test_reset_mid;
    int stale;
    stale = 0;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
    drive(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1);
    drive(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    nChecks++;
    if (bus.out_valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", bus.out_valid);
    end
    nChecks++;
    if (bus.sum !== 16'h0 || bus.cout !== 1'b0) begin
      nFails++; $display("[TB] FAIL midreset_result: got cout=%b sum=%h expected 0/0000", bus.cout, bus.sum);
    end
    nChecks++;
    if (bus.in_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
    end
    for (int n = 0; n < 15; n++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (bus.out_valid !== 1'b0) stale++;
    end
    nChecks++;
    if (stale != 0) begin
      nFails++; $display("[TB] FAIL midreset_stale: got %0d valid cycles expected 0", stale);
    end
  endtask

  task automatic test_random;
    localparam int N = 10000;
    logic [WIDTH:0]   expQ [$];
    logic [WIDTH:0]   expV;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    int               idx;
    int               got;
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 60000 && got < N; cyc++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      v = (idx < N) && ($urandom_range(0, 3) != 0);
      drive(v, x, y, c, $urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        expV = (expQ.size() > 0) ? expQ.pop_front() : '0;
        nChecks++;
        if ({bus.cout, bus.sum} !== expV) begin
          nFails++;
          $display("[TB] FAIL random_result%0d: got %h expected %h", got, {bus.cout, bus.sum}, expV);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back({1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c});
        idx++;
      end
    end
    nChecks++;
    if (got != N || expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL random_count: got %0d results (%0d pending) expected %0d", got, expQ.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
